issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  Age-ordered issue queue + register scoreboard between dual decode and execute. Accepts up to two
//  task_t per cycle from decode. Issues the oldest hazard-free non-memory task to the ALU port and the
//  oldest memory task, in program order among memory tasks, to the MEM port. Register operands are
//  read at issue, so issue is blocked on RAW, WAW and WAR hazards; there is no renaming.
// PARAMETERS
//  DEPTH  8  queue entries (>=4); entry 0 is always the oldest
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RST            in   1      synchronous active-high reset
//  FLUSH          in   1      discard all queued and incoming tasks (branch mispredict/trap)
//  TASK_0         in   task_t older decoded task
//  TASK_1         in   task_t younger decoded task
//  TASK_VALID_0   in   1      TASK_0 present
//  TASK_VALID_1   in   1      TASK_1 present
//  IN_READY       out  1      decode may present tasks this cycle (>=2 free entries)
//  ALU_TASK       out  task_t task issued to ALU/branch unit
//  ALU_VALID      out  1      ALU_TASK valid
//  ALU_READY      in   1      ALU unit accepts
//  MEM_TASK       out  task_t task issued to load/store unit
//  MEM_VALID      out  1      MEM_TASK valid
//  MEM_READY      in   1      memory unit accepts
//  WB_VALID_0/1   in   1      writeback port n retires a register
//  WB_ADDR_0/1    in   5      register written by port n
//  BUSY           out  32     scoreboard vector (debug/verification visibility)
// BEHAVIOUR
//  Reset: all entries invalid, count=0, BUSY=0, ALU_VALID=MEM_VALID=0, IN_READY=1.
//  Enqueue: at the edge, if IN_READY && !FLUSH, valid tasks are appended at the tail, TASK_0 before
//   TASK_1. opcode==NOP tasks are dropped. TASK_VALID_1 alone is legal. Tasks presented while
//   IN_READY=0 are ignored; decode holds them.
//  IN_READY = (count <= DEPTH-2). Combinational from registered count; ignores same-cycle issues
//   (conservative).
//  Eligibility of entry i (combinational from registered state):
//   - rs1_used -> !BUSY[rs1]; rs2_used -> !BUSY[rs2]; rd_used&&rd!=0 -> !BUSY[rd].
//   - For every older valid entry j<i: j.rd (rd_used, !=0) is not i.rs1/i.rs2/i.rd.
//     i.rd is not j.rs1/j.rs2 where used.
//   - MEM class (LOAD/STORE): also must be the oldest MEM entry in the queue.
//  Select: ALU port = lowest-index eligible non-MEM entry; MEM port = oldest MEM entry if eligible.
//   Both may fire in the same cycle. Hazard checks against all older entries make same-cycle
//   conflicts impossible.
//  Issue: ALU_TASK/MEM_TASK/valids are combinational, forced 0 while FLUSH=1. An entry is removed at
//   the edge where VALID&&READY. Remaining entries compact toward 0, preserving order, then new tasks
//   append. Latency: task enqueued at edge N is issuable in cycle N+1 at the earliest.
//  Scoreboard: x0 is never busy. At an issue edge BUSY[rd] is set (rd_used, rd!=0). WB_VALID_n clears
//   BUSY[WB_ADDR_n]. If set and clear hit the same reg in one edge, set wins. No WB bypass into
//   eligibility: a dependent task issues the cycle after writeback.
//  FLUSH: at the edge all entries invalidate and incoming tasks drop. BUSY is unaffected, because
//   in-flight ops still write back. Issue valids are 0 during the FLUSH cycle.
//  Full: count==DEPTH-1 or DEPTH gives IN_READY=0. Simultaneous issue+enqueue must never exceed DEPTH.
//  RST mid-operation overrides FLUSH, enqueue, issue and WB.
// STRUCTURE
//  cpu_types package additions: localparam SCHED_DEPTH=8; function is_mem_op(opcode_t).
//   Reuse existing task_t/opcode_t.
//  Sub-module sched_scoreboard: 32-bit busy vector with 2 set ports + 2 clear ports and set-wins
//   priority. Queue, hazard matrix and select logic stay in issue_scheduler.
// TESTING
//  1 Reset, then ADDI x1 + ADDI x2 in one cycle -> ALU issues x1 task at N+1, x2 task at N+2;
//    BUSY=0x6 after N+2.
//  2 ADD x3,x1,x2 with BUSY[1]=1 -> ALU_VALID=0; WB_VALID_0=1,WB_ADDR_0=1 -> issues the cycle after.
//  3 LW x5,0(x4) then SW x6,4(x7), x4/x7 not busy -> MEM issues LW then SW in order;
//    SW never precedes LW even with MEM_READY toggling.
//  4 Older ADD x8 (blocked on busy x9), younger ADDI x10 -> ADDI issues first (OoO).
//    Younger ADDI x8 stays blocked (WAW).
//  5 Fill DEPTH-1 entries with blocked tasks -> IN_READY=0; TASK_VALID inputs ignored;
//    one issue -> IN_READY=1 next cycle.
//  6 FLUSH with 5 queued tasks + 2 incoming -> count=0 next cycle; BUSY unchanged; valids 0 in flush cycle.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: decoded task payload, opcodes and queue sizing.
package issue_scheduler_pkg;

    localparam int unsigned SCHED_DEPTH = 8;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned NUM_REGS    = 32;
    localparam int unsigned IMM_W       = 12;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_ADD    = 3'd1,
        OP_ADDI   = 3'd2,
        OP_BRANCH = 3'd3,
        OP_LOAD   = 3'd4,
        OP_STORE  = 3'd5
    } opcode_t;

    typedef struct packed {
        opcode_t          opcode;
        logic [REG_W-1:0] rd;
        logic             rd_used;
        logic [REG_W-1:0] rs1;
        logic             rs1_used;
        logic [REG_W-1:0] rs2;
        logic             rs2_used;
        logic [IMM_W-1:0] imm;
    } task_t;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// Register busy vector: two set ports (issue) and two clear ports (writeback); set beats clear.
module issue_scheduler_scoreboard
    import issue_scheduler_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_set_en_0,
    input  logic [REG_W-1:0]    i_set_addr_0,
    input  logic                i_set_en_1,
    input  logic [REG_W-1:0]    i_set_addr_1,
    input  logic                i_clr_en_0,
    input  logic [REG_W-1:0]    i_clr_addr_0,
    input  logic                i_clr_en_1,
    input  logic [REG_W-1:0]    i_clr_addr_1,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_set_en_0) w_set[i_set_addr_0] = 1'b1;
        if (i_set_en_1) w_set[i_set_addr_1] = 1'b1;
        if (i_clr_en_0) w_clr[i_clr_addr_0] = 1'b1;
        if (i_clr_en_1) w_clr[i_clr_addr_1] = 1'b1;
    end

    // x0 is hardwired idle
    always_ff @(posedge i_clk) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/issue_scheduler.sv
// Age-ordered issue queue with RAW/WAW/WAR hazard checks feeding one ALU and one in-order MEM port.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = SCHED_DEPTH
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  task_t               i_task_0,
    input  task_t               i_task_1,
    input  logic                i_task_valid_0,
    input  logic                i_task_valid_1,
    output logic                o_in_ready,
    output task_t               o_alu_task,
    output logic                o_alu_valid,
    input  logic                i_alu_ready,
    output task_t               o_mem_task,
    output logic                o_mem_valid,
    input  logic                i_mem_ready,
    input  logic                i_wb_valid_0,
    input  logic                i_wb_valid_1,
    input  logic [REG_W-1:0]    i_wb_addr_0,
    input  logic [REG_W-1:0]    i_wb_addr_1,
    output logic [NUM_REGS-1:0] o_busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    task_t            r_q [DEPTH];
    logic [CNT_W-1:0] r_count;

    task_t            w_q_nxt [DEPTH];
    logic [CNT_W-1:0] w_wr_ptr;
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_is_mem;
    logic             w_alu_found, w_mem_found;
    logic [IDX_W-1:0] w_alu_idx, w_mem_idx;
    logic             w_alu_fire, w_mem_fire, w_accept;

    function automatic logic f_writes(input task_t t);
        return t.rd_used && (t.rd != '0);
    endfunction

    function automatic logic f_reads(input task_t t, input logic [REG_W-1:0] r);
        return (t.rs1_used && (t.rs1 == r)) || (t.rs2_used && (t.rs2 == r));
    endfunction

    // Older/younger pair that must not issue out of order (also serialises memory ops)
    function automatic logic f_conflict(input task_t older, input task_t younger);
        logic raw_waw;
        logic war;
        raw_waw = f_writes(older) &&
                  (f_reads(younger, older.rd) || (younger.rd_used && (younger.rd == older.rd)));
        war     = f_writes(younger) && f_reads(older, younger.rd);
        return raw_waw || war || (is_mem_op(older.opcode) && is_mem_op(younger.opcode));
    endfunction

    always_comb begin
        w_elig   = '0;
        w_is_mem = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_is_mem[i] = is_mem_op(r_q[i].opcode);
            if (i < int'(r_count)) begin
                w_elig[i] = !((r_q[i].rs1_used && o_busy[r_q[i].rs1]) ||
                              (r_q[i].rs2_used && o_busy[r_q[i].rs2]) ||
                              (f_writes(r_q[i]) && o_busy[r_q[i].rd]));
                for (int j = 0; j < i; j++) begin
                    if (f_conflict(r_q[j], r_q[i])) w_elig[i] = 1'b0;
                end
            end
        end
    end

    // Descending scan so the lowest (oldest) eligible index is the one left selected
    always_comb begin
        w_alu_found = 1'b0;
        w_alu_idx   = '0;
        w_mem_found = 1'b0;
        w_mem_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (w_elig[i] && !w_is_mem[i]) begin
                w_alu_found = 1'b1;
                w_alu_idx   = IDX_W'(i);
            end
            if (w_elig[i] && w_is_mem[i]) begin
                w_mem_found = 1'b1;
                w_mem_idx   = IDX_W'(i);
            end
        end
    end

    assign o_in_ready  = (r_count <= CNT_W'(DEPTH - 2));
    assign o_alu_task  = r_q[w_alu_idx];
    assign o_mem_task  = r_q[w_mem_idx];
    assign o_alu_valid = w_alu_found && !i_flush;
    assign o_mem_valid = w_mem_found && !i_flush;
    assign w_alu_fire  = o_alu_valid && i_alu_ready;
    assign w_mem_fire  = o_mem_valid && i_mem_ready;
    assign w_accept    = o_in_ready && !i_flush;

    // Compact survivors toward entry 0, then append accepted non-NOP tasks in order
    always_comb begin
        w_q_nxt  = r_q;
        w_wr_ptr = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((i < int'(r_count)) &&
                !(w_alu_fire && (int'(w_alu_idx) == i)) &&
                !(w_mem_fire && (int'(w_mem_idx) == i))) begin
                w_q_nxt[IDX_W'(w_wr_ptr)] = r_q[i];
                w_wr_ptr = w_wr_ptr + CNT_W'(1);
            end
        end
        if (w_accept && i_task_valid_0 && (i_task_0.opcode != OP_NOP)) begin
            w_q_nxt[IDX_W'(w_wr_ptr)] = i_task_0;
            w_wr_ptr = w_wr_ptr + CNT_W'(1);
        end
        if (w_accept && i_task_valid_1 && (i_task_1.opcode != OP_NOP)) begin
            w_q_nxt[IDX_W'(w_wr_ptr)] = i_task_1;
            w_wr_ptr = w_wr_ptr + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            r_count <= w_wr_ptr;
            r_q     <= w_q_nxt;
        end
    end

    issue_scheduler_scoreboard u_scoreboard (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_set_en_0   (w_alu_fire && f_writes(o_alu_task)),
        .i_set_addr_0 (o_alu_task.rd),
        .i_set_en_1   (w_mem_fire && f_writes(o_mem_task)),
        .i_set_addr_1 (o_mem_task.rd),
        .i_clr_en_0   (i_wb_valid_0),
        .i_clr_addr_0 (i_wb_addr_0),
        .i_clr_en_1   (i_wb_valid_1),
        .i_clr_addr_1 (i_wb_addr_1),
        .o_busy       (o_busy)
    );

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: queue/bitmask reference model checked every cycle plus literal checkpoints.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int unsigned D = SCHED_DEPTH;

    logic        clk;
    logic        rst, flush;
    task_t       t0, t1;
    logic        v0, v1;
    logic        in_ready;
    task_t       alu_task, mem_task;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic        wbv0, wbv1;
    logic [4:0]  wba0, wba1;
    logic [31:0] busy;

    int checks   = 0;
    int failures = 0;

    issue_scheduler #(.DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_task_0(t0), .i_task_1(t1), .i_task_valid_0(v0), .i_task_valid_1(v1),
        .o_in_ready(in_ready),
        .o_alu_task(alu_task), .o_alu_valid(alu_valid), .i_alu_ready(alu_ready),
        .o_mem_task(mem_task), .o_mem_valid(mem_valid), .i_mem_ready(mem_ready),
        .i_wb_valid_0(wbv0), .i_wb_valid_1(wbv1), .i_wb_addr_0(wba0), .i_wb_addr_1(wba1),
        .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic task_t mk(input opcode_t op, input int rd, input int rs1, input int rs2);
        task_t t;
        t        = '0;
        t.opcode = op;
        t.rd     = 5'(rd);
        t.rs1    = 5'(rs1);
        t.rs2    = 5'(rs2);
        t.imm    = 12'(rd * 7 + rs1 + 3);
        case (op)
            OP_ADD:              begin t.rd_used = 1'b1; t.rs1_used = 1'b1; t.rs2_used = 1'b1; end
            OP_ADDI, OP_LOAD:    begin t.rd_used = 1'b1; t.rs1_used = 1'b1; end
            OP_STORE, OP_BRANCH: begin t.rs1_used = 1'b1; t.rs2_used = 1'b1; end
            default: ;
        endcase
        return t;
    endfunction

    // ---------------- reference model: program-ordered list + busy bitmask ----------------
    task_t       mq[$];
    logic [31:0] mbusy;
    bit          live = 1'b0;

    function automatic logic [31:0] wr_mask(input task_t t);
        return (t.rd_used && t.rd != 5'd0) ? (32'h1 << t.rd) : 32'h0;
    endfunction

    function automatic logic [31:0] rd_mask(input task_t t);
        logic [31:0] m;
        m = 32'h0;
        if (t.rs1_used) m = m | (32'h1 << t.rs1);
        if (t.rs2_used) m = m | (32'h1 << t.rs2);
        return m;
    endfunction

    function automatic bit may_issue(input int i);
        logic [31:0] older_w, older_r, mine;
        bit          older_mem;
        older_w   = 32'h0;
        older_r   = 32'h0;
        older_mem = 1'b0;
        for (int j = 0; j < i; j++) begin
            older_w   = older_w | wr_mask(mq[j]);
            older_r   = older_r | rd_mask(mq[j]);
            older_mem = older_mem | is_mem_op(mq[j].opcode);
        end
        mine = rd_mask(mq[i]) | (mq[i].rd_used ? (32'h1 << mq[i].rd) : 32'h0);
        if (((rd_mask(mq[i]) | wr_mask(mq[i])) & mbusy) != 0) return 1'b0;
        if ((older_w & mine) != 0) return 1'b0;
        if ((wr_mask(mq[i]) & older_r) != 0) return 1'b0;
        if (is_mem_op(mq[i].opcode) && older_mem) return 1'b0;
        return 1'b1;
    endfunction

    initial begin : compare
        int          ea, em, om;
        bit          ein, fa, fm;
        logic [31:0] nb;
        forever begin
            @(negedge clk);
            ea = -1;
            em = -1;
            om = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (is_mem_op(mq[i].opcode)) begin
                    if (om < 0) om = i;
                end else if (ea < 0 && may_issue(i)) begin
                    ea = i;
                end
            end
            if (om >= 0 && may_issue(om)) em = om;
            ein = (mq.size() <= int'(D) - 2);
            if (flush) begin
                ea = -1;
                em = -1;
            end
            if (live) begin
                check("in_ready", 64'(in_ready), 64'(ein));
                check("alu_valid", 64'(alu_valid), 64'(ea >= 0));
                if (ea >= 0) check("alu_task", 64'(alu_task), 64'(mq[ea]));
                check("mem_valid", 64'(mem_valid), 64'(em >= 0));
                if (em >= 0) check("mem_task", 64'(mem_task), 64'(mq[em]));
                check("busy", 64'(busy), 64'(mbusy));
            end
            if (rst) begin
                mq.delete();
                mbusy = 32'h0;
                live  = 1'b1;
            end else begin
                fa = (ea >= 0) && alu_ready;
                fm = (em >= 0) && mem_ready;
                nb = mbusy;
                if (wbv0) nb[wba0] = 1'b0;
                if (wbv1) nb[wba1] = 1'b0;
                if (fa) nb = nb | wr_mask(mq[ea]);
                if (fm) nb = nb | wr_mask(mq[em]);
                nb[0] = 1'b0;
                mbusy = nb;
                if (fa && fm) begin
                    if (ea > em) begin mq.delete(ea); mq.delete(em); end
                    else         begin mq.delete(em); mq.delete(ea); end
                end else if (fa) begin
                    mq.delete(ea);
                end else if (fm) begin
                    mq.delete(em);
                end
                if (flush) mq.delete();
                else if (ein) begin
                    if (v0 && t0.opcode != OP_NOP) mq.push_back(t0);
                    if (v1 && t1.opcode != OP_NOP) mq.push_back(t1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0    = 1'b0;
        v1    = 1'b0;
        flush = 1'b0;
        wbv0  = 1'b0;
        wbv1  = 1'b0;
    endtask

    task automatic clear_all();
        for (int r = 1; r < 32; r += 2) begin
            tick();
            idle();
            wbv0 = 1'b1; wba0 = 5'(r);
            wbv1 = 1'b1; wba1 = 5'(r + 1);
        end
        tick();
        idle();
    endtask

    initial begin : stim
        rst = 1'b1; idle();
        t0 = '0; t1 = '0; wba0 = '0; wba1 = '0;
        alu_ready = 1'b1; mem_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_alu_valid", 64'(alu_valid), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // two independent ADDIs in one cycle, single ALU port
        tick(); t0 = mk(OP_ADDI, 1, 0, 0); t1 = mk(OP_ADDI, 2, 0, 0); v0 = 1'b1; v1 = 1'b1;
        tick(); idle();
        @(negedge clk);
        check("t1_alu_valid_n1", 64'(alu_valid), 64'd1);
        check("t1_alu_rd_n1", 64'(alu_task.rd), 64'd1);
        tick();
        @(negedge clk);
        check("t1_alu_rd_n2", 64'(alu_task.rd), 64'd2);
        check("t1_busy_n2", 64'(busy), 64'h2);
        tick();
        @(negedge clk);
        check("t1_busy_after", 64'(busy), 64'h6);
        check("t1_alu_idle", 64'(alu_valid), 64'd0);

        // issue and writeback of x17 at the same edge: set wins
        tick(); t0 = mk(OP_ADDI, 17, 0, 0); v0 = 1'b1;
        tick(); idle(); wbv0 = 1'b1; wba0 = 5'd17;
        @(negedge clk);
        check("sw_alu_rd", 64'(alu_task.rd), 64'd17);
        tick(); idle();
        @(negedge clk);
        check("sw_busy", 64'(busy), 64'h0002_0006);

        // RAW on x1 released by writeback, issues the cycle after
        tick(); t0 = mk(OP_ADD, 3, 1, 2); v0 = 1'b1;
        wbv1 = 1'b1; wba1 = 5'd2; wbv0 = 1'b1; wba0 = 5'd17;
        tick(); idle(); wbv0 = 1'b1; wba0 = 5'd1;
        @(negedge clk);
        check("t2_busy", 64'(busy), 64'h2);
        check("t2_blocked", 64'(alu_valid), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("t2_issue", 64'(alu_valid), 64'd1);
        check("t2_issue_rd", 64'(alu_task.rd), 64'd3);
        tick();
        @(negedge clk);
        check("t2_busy_after", 64'(busy), 64'h8);
        clear_all();

        // memory ops stay in program order under back-pressure
        mem_ready = 1'b0;
        t0 = mk(OP_LOAD, 5, 4, 0); t1 = mk(OP_STORE, 0, 7, 6); v0 = 1'b1; v1 = 1'b1;
        tick(); idle();
        @(negedge clk);
        check("t3_mem_valid", 64'(mem_valid), 64'd1);
        check("t3_first_lw", 64'(mem_task.opcode), 64'(OP_LOAD));
        tick(); mem_ready = 1'b1;
        @(negedge clk);
        check("t3_lw_again", 64'(mem_task.opcode), 64'(OP_LOAD));
        tick(); mem_ready = 1'b0;
        @(negedge clk);
        check("t3_then_sw", 64'(mem_task.opcode), 64'(OP_STORE));
        tick(); mem_ready = 1'b1;
        @(negedge clk);
        check("t3_sw_valid", 64'(mem_valid), 64'd1);
        tick();
        @(negedge clk);
        check("t3_mem_drained", 64'(mem_valid), 64'd0);
        clear_all();

        // younger independent task bypasses a blocked older one; WAW holds the younger x8
        t0 = mk(OP_ADDI, 9, 0, 0); v0 = 1'b1;
        tick(); idle(); t0 = mk(OP_ADD, 8, 9, 9); t1 = mk(OP_ADDI, 10, 0, 0); v0 = 1'b1; v1 = 1'b1;
        tick(); idle(); t0 = mk(OP_ADDI, 8, 0, 0); v0 = 1'b1;
        @(negedge clk);
        check("t4_ooo_rd", 64'(alu_task.rd), 64'd10);
        tick(); idle();
        @(negedge clk);
        check("t4_waw_block", 64'(alu_valid), 64'd0);
        tick(); idle(); wbv0 = 1'b1; wba0 = 5'd9;
        @(negedge clk);
        check("t4_no_bypass", 64'(alu_valid), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("t4_add_op", 64'(alu_task.opcode), 64'(OP_ADD));
        check("t4_add_valid", 64'(alu_valid), 64'd1);
        tick(); idle(); wbv0 = 1'b1; wba0 = 5'd8;
        @(negedge clk);
        check("t4_addi_busy", 64'(alu_valid), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("t4_addi_op", 64'(alu_task.opcode), 64'(OP_ADDI));
        clear_all();

        // fill DEPTH-1 blocked entries, held tasks wait for space
        t0 = mk(OP_ADDI, 20, 0, 0); v0 = 1'b1;
        tick(); t0 = mk(OP_ADD, 21, 20, 0); t1 = mk(OP_ADD, 22, 20, 0); v1 = 1'b1;
        tick(); t0 = mk(OP_ADD, 23, 20, 0); t1 = mk(OP_ADD, 24, 20, 0);
        tick(); t0 = mk(OP_ADD, 25, 20, 0); t1 = mk(OP_ADD, 26, 20, 0);
        tick(); t0 = mk(OP_ADD, 27, 20, 0); v1 = 1'b0;
        tick(); idle(); t0 = mk(OP_ADDI, 28, 0, 0); t1 = mk(OP_ADDI, 29, 0, 0); v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("t5_full", 64'(in_ready), 64'd0);
        check("t5_all_blocked", 64'(alu_valid), 64'd0);
        tick(); wbv0 = 1'b1; wba0 = 5'd20;
        @(negedge clk);
        check("t5_still_full", 64'(in_ready), 64'd0);
        tick(); wbv0 = 1'b0;
        @(negedge clk);
        check("t5_issue_rd", 64'(alu_task.rd), 64'd21);
        check("t5_full_issuing", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        check("t5_ready_again", 64'(in_ready), 64'd1);
        tick(); idle();
        repeat (10) tick();
        @(negedge clk);
        check("t5_drained", 64'(alu_valid), 64'd0);
        clear_all();

        // flush with 5 queued + 2 incoming; busy survives
        mem_ready = 1'b0;
        t0 = mk(OP_ADDI, 20, 0, 0); v0 = 1'b1;
        tick(); t0 = mk(OP_ADD, 11, 20, 0); t1 = mk(OP_ADD, 12, 20, 0); v1 = 1'b1;
        tick(); t0 = mk(OP_ADD, 13, 20, 0); t1 = mk(OP_ADD, 14, 20, 0);
        tick(); t0 = mk(OP_LOAD, 16, 0, 0); v1 = 1'b0;
        tick(); idle();
        @(negedge clk);
        check("t6_pre_mem", 64'(mem_valid), 64'd1);
        tick(); flush = 1'b1; mem_ready = 1'b1;
        t0 = mk(OP_ADDI, 1, 0, 0); t1 = mk(OP_ADDI, 2, 0, 0); v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("t6_flush_mem", 64'(mem_valid), 64'd0);
        check("t6_flush_alu", 64'(alu_valid), 64'd0);
        tick(); idle();
        @(negedge clk);
        check("t6_empty_ready", 64'(in_ready), 64'd1);
        check("t6_empty_mem", 64'(mem_valid), 64'd0);
        check("t6_empty_alu", 64'(alu_valid), 64'd0);
        check("t6_busy_kept", 64'(busy), 64'h0010_0000);
        tick();
        @(negedge clk);
        check("t6_still_empty", 64'(mem_valid | alu_valid), 64'd0);

        // reset mid-operation wins over flush, enqueue, issue and writeback
        tick(); t0 = mk(OP_ADD, 5, 20, 0); t1 = mk(OP_ADDI, 6, 0, 0); v0 = 1'b1; v1 = 1'b1;
        tick(); idle(); rst = 1'b1; wbv0 = 1'b1; wba0 = 5'd20;
        t0 = mk(OP_ADDI, 7, 0, 0); v0 = 1'b1;
        tick(); rst = 1'b0; idle();
        @(negedge clk);
        check("t7_busy", 64'(busy), 64'd0);
        check("t7_in_ready", 64'(in_ready), 64'd1);
        check("t7_alu_valid", 64'(alu_valid), 64'd0);
        tick(); t0 = mk(OP_ADDI, 4, 0, 0); v0 = 1'b1;
        tick(); idle();
        @(negedge clk);
        check("t7_post_issue", 64'(alu_task.rd), 64'd4);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
